// File: rtl/branch_pc_if.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pc_if
//  Description : Execute-stage bus between the decoder/ALU side and the
//                branch/PC unit. The master drives the retiring instruction,
//                and the slave returns PC, carry and the result pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
interface branch_pc_if #(
    parameter int ADDR_W = 32
);
    // Instruction side (decoder / ALU -> branch unit)
    logic              ex_valid;
    logic              stall;
    logic [3:0]        br_op;
    logic [2:0]        alu_flag;
    logic              carry_we;
    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] reg_target;

    // Result side (branch unit -> fetch / register file)
    logic [ADDR_W-1:0] pc;
    logic              carry_q;
    logic              link_we;
    logic [ADDR_W-1:0] link_data;
    logic              taken;
    logic              misalign;
    logic              illegal;
    logic              halted;

    modport master (
        output ex_valid, stall, br_op, alu_flag, carry_we, br_off, reg_target,
        input  pc, carry_q, link_we, link_data, taken, misalign, illegal, halted
    );

    modport slave (
        input  ex_valid, stall, br_op, alu_flag, carry_we, br_off, reg_target,
        output pc, carry_q, link_we, link_data, taken, misalign, illegal, halted
    );
endinterface
`default_nettype wire

// File: rtl/branch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : branch_pc_unit
//  Description : Holds the architectural PC and carry flag, resolves
//                conditional/unconditional branches from ALU flags, produces
//                link writes for bl and handles the sticky halt state.
//                All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_pc_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  wire logic  clk,
    input  wire logic  rst,
    branch_pc_if.slave bus
);

    // Branch opcode encoding
    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_B    = 4'b0001;
    localparam logic [3:0] OP_BR   = 4'b0010;
    localparam logic [3:0] OP_BLTZ = 4'b0011;
    localparam logic [3:0] OP_BZ   = 4'b0100;
    localparam logic [3:0] OP_BNZ  = 4'b0101;
    localparam logic [3:0] OP_BL   = 4'b0110;
    localparam logic [3:0] OP_BCY  = 4'b0111;
    localparam logic [3:0] OP_BNCY = 4'b1000;
    localparam logic [3:0] OP_HALT = 4'b1111;

    // Only two modes: running, or halted until reset
    typedef enum logic [0:0] {
        MODE_RUN  = 1'b0,
        MODE_HALT = 1'b1
    } mode_t;

    mode_t             mode_q;
    logic [ADDR_W-1:0] pc_q;
    logic              carry_q;
    logic              link_we_q;
    logic [ADDR_W-1:0] link_data_q;
    logic              taken_q;
    logic              misalign_q;
    logic              illegal_q;

    logic              adv;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] rel_addr;
    logic [ADDR_W-1:0] pc_d;
    logic              taken_d;
    logic              link_we_d;
    logic              misalign_d;
    logic              illegal_d;
    logic              halt_d;

    // An instruction retires only when valid, not frozen and not halted
    assign adv      = bus.ex_valid & ~bus.stall & (mode_q == MODE_RUN);
    // Both targets wrap silently modulo 2^ADDR_W
    assign seq_addr = pc_q + ADDR_W'(4);
    assign rel_addr = seq_addr + bus.br_off;

    // Next-PC selection and pulse decode; conditional branches see the carry
    // flag as it stood before this edge's carry_we update
    always_comb begin
        pc_d       = seq_addr;
        taken_d    = 1'b0;
        link_we_d  = 1'b0;
        misalign_d = 1'b0;
        illegal_d  = 1'b0;
        halt_d     = 1'b0;
        unique case (bus.br_op)
            OP_NONE: pc_d = seq_addr;
            OP_B: begin
                pc_d    = rel_addr;
                taken_d = 1'b1;
            end
            OP_BR: begin
                pc_d       = {bus.reg_target[ADDR_W-1:2], 2'b00};
                taken_d    = 1'b1;
                misalign_d = (bus.reg_target[1:0] != 2'b00);
            end
            OP_BLTZ: begin
                taken_d = bus.alu_flag[1];
                pc_d    = bus.alu_flag[1] ? rel_addr : seq_addr;
            end
            OP_BZ: begin
                taken_d = bus.alu_flag[0];
                pc_d    = bus.alu_flag[0] ? rel_addr : seq_addr;
            end
            OP_BNZ: begin
                taken_d = ~bus.alu_flag[0];
                pc_d    = bus.alu_flag[0] ? seq_addr : rel_addr;
            end
            OP_BL: begin
                pc_d      = rel_addr;
                taken_d   = 1'b1;
                link_we_d = 1'b1;
            end
            OP_BCY: begin
                taken_d = carry_q;
                pc_d    = carry_q ? rel_addr : seq_addr;
            end
            OP_BNCY: begin
                taken_d = ~carry_q;
                pc_d    = carry_q ? seq_addr : rel_addr;
            end
            OP_HALT: begin
                pc_d   = pc_q;
                halt_d = 1'b1;
            end
            default: begin
                pc_d      = seq_addr;
                illegal_d = 1'b1;
            end
        endcase
    end

    // Architectural state, mode and registered result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q      <= MODE_RUN;
            pc_q        <= RESET_PC;
            carry_q     <= 1'b0;
            link_we_q   <= 1'b0;
            link_data_q <= '0;
            taken_q     <= 1'b0;
            misalign_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            // Pulses default low; they only fire on a retiring edge
            link_we_q  <= 1'b0;
            taken_q    <= 1'b0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
            if (adv) begin
                pc_q       <= pc_d;
                link_we_q  <= link_we_d;
                taken_q    <= taken_d;
                misalign_q <= misalign_d;
                illegal_q  <= illegal_d;
                if (bus.carry_we) begin
                    carry_q <= bus.alu_flag[2];
                end
                if (link_we_d) begin
                    link_data_q <= seq_addr;
                end
                if (halt_d) begin
                    mode_q <= MODE_HALT;
                end
            end
        end
    end

    assign bus.pc        = pc_q;
    assign bus.carry_q   = carry_q;
    assign bus.link_we   = link_we_q;
    assign bus.link_data = link_data_q;
    assign bus.taken     = taken_q;
    assign bus.misalign  = misalign_q;
    assign bus.illegal   = illegal_q;
    assign bus.halted    = (mode_q == MODE_HALT);

endmodule
`default_nettype wire

// File: tb/tb_branch_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_pc_unit
//  Description : Directed self-checking bench for branch_pc_unit. Each task
//                drives one scenario and compares outputs against
//                hand-computed values one cycle after each retiring edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_pc_unit;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    branch_pc_if #(.ADDR_W(32)) bus ();

    branch_pc_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move the PC to an aligned address with a br instruction
    task automatic set_pc(input logic [31:0] addr);
        bus.ex_valid   = 1'b1;
        bus.stall      = 1'b0;
        bus.carry_we   = 1'b0;
        bus.br_op      = 4'b0010;
        bus.reg_target = addr;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.ex_valid = 1'b1; bus.stall = 1'b0; bus.br_op = 4'b0001;
        bus.alu_flag = 3'b111; bus.carry_we = 1'b1;
        bus.br_off = 32'h40; bus.reg_target = 32'h0;
        tick(); tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", bus.pc, 32'h0); end
        checks++; if (bus.carry_q !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", bus.carry_q); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
        checks++; if ({bus.taken, bus.link_we, bus.misalign, bus.illegal} !== 4'b0000) begin errors++; $display("FAIL reset_pulses: got %b want 0000", {bus.taken, bus.link_we, bus.misalign, bus.illegal}); end
        checks++; if (bus.link_data !== 32'h0) begin errors++; $display("FAIL reset_link_data: got %h want 0", bus.link_data); end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc [3] = '{32'h4, 32'h8, 32'hC};
        bus.br_op = 4'b0000; bus.carry_we = 1'b0; bus.alu_flag = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc !== exp_pc[i]) begin errors++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc, exp_pc[i]); end
            checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL seq_taken[%0d]: got %b want 0", i, bus.taken); end
        end
        checks++; if (bus.carry_q !== 1'b0) begin errors++; $display("FAIL seq_carry: got %b want 0", bus.carry_q); end
        // Bubble: ex_valid low holds the PC
        bus.ex_valid = 1'b0; tick();
        checks++; if (bus.pc !== 32'hC) begin errors++; $display("FAIL bubble_pc: got %h want %h", bus.pc, 32'hC); end
        bus.ex_valid = 1'b1;
    endtask

    task automatic test_cond_branch();
        set_pc(32'h10);
        bus.br_op = 4'b0011; bus.alu_flag = 3'b010; bus.br_off = 32'hFFFF_FFF8; tick();
        checks++; if (bus.pc !== 32'h0C) begin errors++; $display("FAIL bltz_taken_pc: got %h want %h", bus.pc, 32'h0C); end
        checks++; if (bus.taken !== 1'b1) begin errors++; $display("FAIL bltz_taken: got %b want 1", bus.taken); end
        bus.br_op = 4'b0000; tick();
        checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL taken_one_cycle: got %b want 0", bus.taken); end
        set_pc(32'h10);
        bus.br_op = 4'b0011; bus.alu_flag = 3'b000; tick();
        checks++; if (bus.pc !== 32'h14) begin errors++; $display("FAIL bltz_not_pc: got %h want %h", bus.pc, 32'h14); end
        checks++; if (bus.taken !== 1'b0) begin errors++; $display("FAIL bltz_not_taken: got %b want 0", bus.taken); end
        // bz taken then bnz not taken on the same zero flag
        set_pc(32'h40);
        bus.br_op = 4'b0100; bus.alu_flag = 3'b001; bus.br_off = 32'h10; tick();
        checks++; if (bus.pc !== 32'h54) begin errors++; $display("FAIL bz_pc: got %h want %h", bus.pc, 32'h54); end
        bus.br_op = 4'b0101; tick();
        checks++; if (bus.pc !== 32'h58 || bus.taken !== 1'b0) begin errors++; $display("FAIL bnz_not: got pc=%h taken=%b want pc=58 taken=0", bus.pc, bus.taken); end
        bus.alu_flag = 3'b000; tick();
        checks++; if (bus.pc !== 32'h6C || bus.taken !== 1'b1) begin errors++; $display("FAIL bnz_taken: got pc=%h taken=%b want pc=6c taken=1", bus.pc, bus.taken); end
    endtask

    task automatic test_carry();
        set_pc(32'h2C);
        bus.br_op = 4'b0000; bus.carry_we = 1'b1; bus.alu_flag = 3'b100; tick();
        checks++; if (bus.pc !== 32'h30 || bus.carry_q !== 1'b1) begin errors++; $display("FAIL add_carry: got pc=%h carry=%b want pc=30 carry=1", bus.pc, bus.carry_q); end
        // bcy uses carry_q, not alu_flag[2]
        bus.br_op = 4'b0111; bus.carry_we = 1'b0; bus.alu_flag = 3'b000; bus.br_off = 32'h20; tick();
        checks++; if (bus.pc !== 32'h54 || bus.taken !== 1'b1) begin errors++; $display("FAIL bcy_taken: got pc=%h taken=%b want pc=54 taken=1", bus.pc, bus.taken); end
        bus.br_op = 4'b1000; tick();
        checks++; if (bus.pc !== 32'h58 || bus.taken !== 1'b0) begin errors++; $display("FAIL bncy_not: got pc=%h taken=%b want pc=58 taken=0", bus.pc, bus.taken); end
        bus.br_op = 4'b0000; bus.carry_we = 1'b1; bus.alu_flag = 3'b000; tick();
        checks++; if (bus.pc !== 32'h5C || bus.carry_q !== 1'b0) begin errors++; $display("FAIL clear_carry: got pc=%h carry=%b want pc=5c carry=0", bus.pc, bus.carry_q); end
        // Same-cycle update: branch sees the old carry (0)
        bus.br_op = 4'b0111; bus.carry_we = 1'b1; bus.alu_flag = 3'b100; tick();
        checks++; if (bus.pc !== 32'h60 || bus.taken !== 1'b0) begin errors++; $display("FAIL bcy_same_cycle: got pc=%h taken=%b want pc=60 taken=0", bus.pc, bus.taken); end
        checks++; if (bus.carry_q !== 1'b1) begin errors++; $display("FAIL bcy_same_cycle_carry: got %b want 1", bus.carry_q); end
        bus.carry_we = 1'b0; bus.alu_flag = 3'b000;
    endtask

    task automatic test_link();
        set_pc(32'h100);
        bus.br_op = 4'b0110; bus.br_off = 32'h40; tick();
        checks++; if (bus.pc !== 32'h144 || bus.taken !== 1'b1) begin errors++; $display("FAIL bl_pc: got pc=%h taken=%b want pc=144 taken=1", bus.pc, bus.taken); end
        checks++; if (bus.link_we !== 1'b1 || bus.link_data !== 32'h104) begin errors++; $display("FAIL bl_link: got we=%b data=%h want we=1 data=104", bus.link_we, bus.link_data); end
        bus.br_op = 4'b0000; tick();
        checks++; if (bus.link_we !== 1'b0 || bus.link_data !== 32'h104 || bus.pc !== 32'h148) begin errors++; $display("FAIL bl_after: got we=%b data=%h pc=%h want we=0 data=104 pc=148", bus.link_we, bus.link_data, bus.pc); end
        bus.br_op = 4'b0010; bus.reg_target = 32'h203; tick();
        checks++; if (bus.pc !== 32'h200 || bus.misalign !== 1'b1 || bus.taken !== 1'b1) begin errors++; $display("FAIL br_misalign: got pc=%h mis=%b taken=%b want pc=200 mis=1 taken=1", bus.pc, bus.misalign, bus.taken); end
        bus.br_op = 4'b0000; tick();
        checks++; if (bus.misalign !== 1'b0 || bus.pc !== 32'h204) begin errors++; $display("FAIL misalign_pulse: got mis=%b pc=%h want mis=0 pc=204", bus.misalign, bus.pc); end
    endtask

    task automatic test_stall_illegal();
        set_pc(32'h80);
        bus.br_op = 4'b0000; tick();
        // carry_q is 1 here; a stalled carry_we must not clear it
        bus.stall = 1'b1; bus.br_op = 4'b0001; bus.br_off = 32'h10;
        bus.carry_we = 1'b1; bus.alu_flag = 3'b000;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.pc !== 32'h84 || bus.carry_q !== 1'b1 || bus.taken !== 1'b0) begin errors++; $display("FAIL stall[%0d]: got pc=%h carry=%b taken=%b want pc=84 carry=1 taken=0", i, bus.pc, bus.carry_q, bus.taken); end
        end
        bus.stall = 1'b0; bus.carry_we = 1'b0; tick();
        checks++; if (bus.pc !== 32'h98 || bus.taken !== 1'b1) begin errors++; $display("FAIL stall_release: got pc=%h taken=%b want pc=98 taken=1", bus.pc, bus.taken); end
        bus.br_op = 4'b0000; tick();
        checks++; if (bus.pc !== 32'h9C || bus.taken !== 1'b0) begin errors++; $display("FAIL stall_once: got pc=%h taken=%b want pc=9c taken=0", bus.pc, bus.taken); end
        bus.br_op = 4'b1010; tick();
        checks++; if (bus.pc !== 32'hA0 || bus.illegal !== 1'b1) begin errors++; $display("FAIL illegal: got pc=%h ill=%b want pc=a0 ill=1", bus.pc, bus.illegal); end
        bus.br_op = 4'b0000; tick();
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got %b want 0", bus.illegal); end
    endtask

    task automatic test_halt_wrap();
        set_pc(32'h20);
        bus.br_op = 4'b1111; tick();
        checks++; if (bus.pc !== 32'h20 || bus.halted !== 1'b1) begin errors++; $display("FAIL halt: got pc=%h halted=%b want pc=20 halted=1", bus.pc, bus.halted); end
        bus.br_op = 4'b0001; bus.br_off = 32'h40; tick(); tick();
        checks++; if (bus.pc !== 32'h20 || bus.halted !== 1'b1 || bus.taken !== 1'b0) begin errors++; $display("FAIL halt_hold: got pc=%h halted=%b taken=%b want pc=20 halted=1 taken=0", bus.pc, bus.halted, bus.taken); end
        rst = 1'b1; bus.stall = 1'b1; tick();
        checks++; if (bus.pc !== 32'h0 || bus.halted !== 1'b0 || bus.carry_q !== 1'b0) begin errors++; $display("FAIL halt_reset: got pc=%h halted=%b carry=%b want pc=0 halted=0 carry=0", bus.pc, bus.halted, bus.carry_q); end
        rst = 1'b0; bus.stall = 1'b0;
        set_pc(32'hFFFF_FFFC);
        bus.br_op = 4'b0000; tick();
        checks++; if (bus.pc !== 32'h0) begin errors++; $display("FAIL wrap_seq: got %h want 0", bus.pc); end
        set_pc(32'hFFFF_FFF0);
        bus.br_op = 4'b0001; bus.br_off = 32'h10; tick();
        checks++; if (bus.pc !== 32'h4) begin errors++; $display("FAIL wrap_rel: got %h want 4", bus.pc); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        test_reset();
        test_sequential();
        test_cond_branch();
        test_carry();
        test_link();
        test_stall_illegal();
        test_halt_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
- Execute-stage neighbour directly downstream of the ALU.
- Consumes the ALU status flags (bit0 rs==0, bit1 rs<0, bit2 add carry) and the decoded branch opcode.
- Holds the architectural program counter and the persistent carry flag, resolves conditional/unconditional branches, generates link writes for bl, and handles halt.
- Output pc drives instruction fetch.

Parameters:
ADDR_W, 32, width of pc, offsets and link data
RESET_PC, 0, pc value loaded on reset

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  an instruction is in execute this cycle
stall  in  1  freeze: no state change when 1
br_op  in  4  branch opcode from decoder
alu_flag  in  3  ALU flag bus [0]=rs zero, [1]=rs negative, [2]=carry
carry_we  in  1  current instruction is an add-class op; capture alu_flag[2]
br_off  in  ADDR_W  signed byte offset for PC-relative branches
reg_target  in  ADDR_W  rs value for br (register-indirect)
pc  out  ADDR_W  current program counter
carry_q  out  1  architectural carry flag
link_we  out  1  one-cycle pulse: write link_data to ra
link_data  out  ADDR_W  return address for bl
taken  out  1  one-cycle pulse: last retired instruction redirected pc
misalign  out  1  one-cycle pulse: br target had nonzero bits [1:0]
illegal  out  1  one-cycle pulse: undefined br_op retired
halted  out  1  sticky halt indicator

Behaviour:
- Reset (rst=1 at edge): pc=RESET_PC, carry_q=0, halted=0; link_we, link_data, taken, misalign, illegal all 0. Reset overrides stall, halt and everything else; applies mid-operation, including from halted.
- Retire condition `adv = ex_valid & ~stall & ~halted`. When adv=0: pc, carry_q and halted hold; all pulse outputs go 0 next edge.
- All outputs are registered. pc_next computes combinationally; the new pc and pulses are visible the cycle after adv.
- seq = pc + 4; rel = pc + 4 + br_off. Both are modulo 2^ADDR_W, so wrap-around is silent.
- br_op encoding, applied on adv:
  - 0000 none: pc=seq.
  - 0001 b: pc=rel, taken=1.
  - 0010 br: pc={reg_target[ADDR_W-1:2],2'b00}, taken=1; misalign=1 if reg_target[1:0]!=0.
  - 0011 bltz: if alu_flag[1], pc=rel and taken=1; else pc=seq.
  - 0100 bz: condition alu_flag[0].
  - 0101 bnz: condition ~alu_flag[0].
  - 0110 bl: pc=rel, taken=1, link_we=1, link_data=seq (old pc+4).
  - 0111 bcy: condition carry_q.
  - 1000 bncy: condition ~carry_q.
  - 1111 halt: pc holds, halted=1 (sticky until rst).
  - others: pc=seq, illegal=1.
- Carry: on adv with carry_we=1, carry_q <= alu_flag[2]. Branch evaluation always uses carry_q before this edge's update. bcy/bncy never sample alu_flag[2] directly.
- carry_we with a branch br_op in the same cycle is legal: both actions occur.
- link_data holds its last value when link_we=0.
- No internal FSM beyond two modes, RUN (halted=0) and HALT (halted=1). RUN->HALT on adv with br_op=1111. HALT->RUN only via rst.

Test Plan:
1. Reset then 3 cycles ex_valid=1, br_op=0000 -> pc 0,4,8,12; taken=0; carry_q=0.
2. pc=0x10, br_op=0011 with alu_flag=3'b010 -> pc=0x14+br_off (br_off=-8 gives 0x0C), taken=1 one cycle. Same with alu_flag=3'b000 -> pc=0x14.
3. Add with carry_we=1, alu_flag[2]=1; next instr bcy, br_off=0x20 at pc=0x30 -> pc=0x54. Same-cycle carry_we=1 plus bcy with carry_q=0 -> not taken, carry_q becomes 1.
4. bl at pc=0x100, br_off=0x40 -> pc=0x144, link_we=1 and link_data=0x104 for exactly one cycle. br with reg_target=0x203 -> pc=0x200, misalign=1.
5. stall=1 for 3 cycles during br_op=0001 -> pc, carry_q frozen, no pulses. Release -> branch retires once. br_op=1010 -> pc+4, illegal=1.
6. halt at pc=0x20 -> halted=1, pc stays 0x20 despite ex_valid. rst=1 asserted alongside stall=1 -> pc=0, halted=0 next edge. pc=0xFFFFFFFC, br_op=0000 -> pc wraps to 0.
